// File: rtl/serial_link_phy_tx_mc_if.sv
// Beat handshake bundle for the serial link PHY transmitter.
//   data_out       : beat payload, channel c at [c*2*NumLanes +: 2*NumLanes]
//   data_out_valid : source has a beat
//   data_out_ready : PHY takes the beat this cycle (valid & ready)
// master = beat source, slave = PHY.
interface serial_link_phy_tx_mc_if #(
  parameter int NumChannels = 2,
  parameter int NumLanes    = 8
);
  logic [NumChannels*2*NumLanes-1:0] data_out;
  logic                              data_out_valid;
  logic                              data_out_ready;

  modport master (output data_out, data_out_valid, input data_out_ready);
  modport slave  (input data_out, data_out_valid, output data_out_ready);
endinterface

// File: rtl/serial_link_phy_tx_mc.sv
// Multi-channel source-synchronous serial link transmitter.
// Each accepted beat is held for div_q clk_i cycles. In DDR mode the low half
// of a channel's payload is driven for the first div_q/2 cycles and the high
// half for the rest; in SDR mode only the low half is driven. A forwarded
// clock per channel toggles at two programmable positions within the beat.
// Ports:
//   clk_i, rst_ni       : clock, async active-low reset
//   ddr_en_i            : 1=DDR, 0=SDR (latched at burst start)
//   clk_div_i           : beat period in cycles, clamped to [2, MaxClkDiv]
//   clk_shift_start_i   : first forwarded-clock toggle position
//   clk_shift_end_i     : second forwarded-clock toggle position
//   channel_en_i        : per-channel enable mask
//   beat_if             : payload valid/ready handshake (slave side)
//   busy_o              : high while a burst is in flight
//   ddr_rcv_clk_o       : forwarded clock per channel
//   ddr_o               : lane data, channel c at [c*NumLanes +: NumLanes]

// Per-channel output stage: registered lanes and forwarded clock.
module serial_link_phy_tx_mc_chan #(
  parameter int NumLanes = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run,     // channel active in the next cycle
  input  logic                  low,     // next cycle drives the low half
  input  logic                  toggle,  // current cycle is a toggle position
  input  logic [2*NumLanes-1:0] data,    // payload for the next cycle
  output logic                  rcv_clk,
  output logic [NumLanes-1:0]   lanes
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcv_clk <= 1'b0;
      lanes   <= '0;
    end else begin
      lanes <= run ? (low ? data[NumLanes-1:0] : data[2*NumLanes-1:NumLanes]) : '0;
      // Clock level carries across back-to-back beats; dropping out of the
      // burst parks it low on the same edge.
      if (!run)        rcv_clk <= 1'b0;
      else if (toggle) rcv_clk <= ~rcv_clk;
    end
  end
endmodule

module serial_link_phy_tx_mc #(
  parameter int NumChannels = 2,
  parameter int NumLanes    = 8,
  parameter int MaxClkDiv   = 32,
  localparam int CW         = $clog2(MaxClkDiv) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            ddr_en_i,
  input  logic [CW-1:0]                   clk_div_i,
  input  logic [CW-1:0]                   clk_shift_start_i,
  input  logic [CW-1:0]                   clk_shift_end_i,
  input  logic [NumChannels-1:0]          channel_en_i,
  serial_link_phy_tx_mc_if.slave         beat_if,
  output logic                            busy_o,
  output logic [NumChannels-1:0]          ddr_rcv_clk_o,
  output logic [NumChannels*NumLanes-1:0] ddr_o
);
  localparam int DW = NumChannels * 2 * NumLanes;

  typedef enum logic {IDLE, ACTIVE} state_e;

  typedef struct packed {
    logic                   ddr_en;
    logic [CW-1:0]          div;
    logic [CW-1:0]          start;
    logic [CW-1:0]          stop;
    logic [NumChannels-1:0] mask;
  } cfg_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  cfg_t          cfg_q, cfg_d;
  logic [CW-1:0] div_clamped;
  logic          last, slot, hs, toggle, low_d, run_d;

  always_comb begin
    if (clk_div_i < CW'(2))              div_clamped = CW'(2);
    else if (clk_div_i > CW'(MaxClkDiv)) div_clamped = CW'(MaxClkDiv);
    else                                 div_clamped = clk_div_i;
  end

  // A new beat can be taken when idle or in the final cycle of a beat.
  assign last = (state_q == ACTIVE) && (cnt_q == cfg_q.div - CW'(1));
  assign slot = (state_q == IDLE) || last;
  assign hs   = beat_if.data_out_valid && slot;
  assign beat_if.data_out_ready = beat_if.data_out_valid && slot;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    data_d  = data_q;
    cfg_d   = cfg_q;
    if (hs) data_d = beat_if.data_out;
    if (state_q == IDLE) begin
      if (hs) begin
        state_d      = ACTIVE;
        cfg_d.ddr_en = ddr_en_i;
        cfg_d.div    = div_clamped;
        cfg_d.start  = clk_shift_start_i;
        cfg_d.stop   = clk_shift_end_i;
        cfg_d.mask   = channel_en_i;
      end
    end else if (last) begin
      if (!hs) state_d = IDLE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    run_d = (state_d == ACTIVE);
    low_d = !cfg_d.ddr_en || (cnt_d < (cfg_d.div >> 1));
    // cnt_q never reaches div_q, so positions >= div_q cannot match.
    toggle = (state_q == ACTIVE) && ((cnt_q == cfg_q.start) || (cnt_q == cfg_q.stop));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
    end
  end

  assign busy_o = (state_q == ACTIVE);

  // Output registers are loaded with the values of the coming cycle so that
  // a beat accepted in cycle t is on the wires from cycle t+1.
  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    serial_link_phy_tx_mc_chan #(.NumLanes(NumLanes)) u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .run     (run_d && cfg_d.mask[c]),
      .low     (low_d),
      .toggle  (toggle),
      .data    (data_d[c*2*NumLanes +: 2*NumLanes]),
      .rcv_clk (ddr_rcv_clk_o[c]),
      .lanes   (ddr_o[c*NumLanes +: NumLanes])
    );
  end
endmodule
